// File: rtl/arr_arb_pkg.sv
// Shared types and helpers for the arr_* port arbiter: FSM state encoding,
// index-width helper, default bus widths.
package arr_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int ARB_ADDR_W_DEF = 10;
    localparam int ARB_DATA_W_DEF = 64;

    function automatic int arb_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/arr_port_arbiter_if.sv
// Requester-side bundle for the arbiter: packed per-requester request/lock/we/addr/wdata,
// with one-hot grant, per-requester read-valid and broadcast read data coming back.
interface arr_port_arbiter_if
    import arr_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ARB_ADDR_W_DEF,
    parameter int DATA_W  = ARB_DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/arr_arb_rr_pick.sv
// Rotating-priority picker: first set req bit scanning cyclically from start_i.
// Purely combinational, zero latency; no backpressure (vld_o=0 when req_i is empty).
module arr_arb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (int'(start_i) + k) % NUM_REQ;
            if (!vld_o && req_i[c]) begin
                vld_o    = 1'b1;
                idx_o    = IDX_W'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arr_port_arbiter.sv
// Round-robin arbiter with RMW lock in front of a 1-cycle-read arr_* memory; grant is same-cycle,
// rvalid one cycle after a read grant; losers simply wait (no queueing). ARR_ARB_BOUNDS_EN adds addr >= DEPTH squash + err.
module arr_port_arbiter
    import arr_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ARB_ADDR_W_DEF,
    parameter int DATA_W  = ARB_DATA_W_DEF,
    parameter int DEPTH   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    arr_port_arbiter_if.slave req_if,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int              IDX_W   = arb_idx_w(NUM_REQ);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef ARR_ARB_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic               err_q;
    logic               rzero_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    logic               held;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   win;
    logic               any_gnt;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               oob;

    arr_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_if.req),
        .start_i (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .vld_o   (pick_vld)
    );

    // A lock only binds while its owner keeps requesting; dropping req frees the port this cycle.
    always_comb begin
        held    = (state_q == ARB_LOCKED) && req_if.req[owner_q];
        gnt     = '0;
        win     = pick_idx;
        any_gnt = 1'b0;
        if (rst_n) begin
            if (held) begin
                gnt[owner_q] = 1'b1;
                win          = owner_q;
                any_gnt      = 1'b1;
            end else begin
                gnt     = pick_gnt;
                any_gnt = pick_vld;
            end
        end
        sel_we    = any_gnt & req_if.we[win];
        sel_addr  = any_gnt ? req_if.addr[int'(win)*ADDR_W +: ADDR_W]  : '0;
        sel_wdata = any_gnt ? req_if.wdata[int'(win)*DATA_W +: DATA_W] : '0;
        oob       = BOUNDS_EN && any_gnt && ({1'b0, sel_addr} >= DEPTH_L);
    end

    always_comb begin
        state_d  = ARB_IDLE;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        rvalid_d = (any_gnt && !sel_we) ? gnt : '0;
        if (any_gnt) begin
            if (held) begin
                state_d = req_if.lock[win] ? ARB_LOCKED : ARB_IDLE;
            end else begin
                ptr_d = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
                if (req_if.lock[win]) begin
                    state_d = ARB_LOCKED;
                    owner_d = win;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            rzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            err_q    <= oob;
            rzero_q  <= oob & ~sel_we;
        end
    end

    assign req_if.gnt    = gnt;
    assign req_if.rvalid = rvalid_q;
    assign req_if.rdata  = rzero_q ? '0 : mem_rdata_i;
    assign mem_we_o      = sel_we & ~oob;
    assign mem_addr_o    = oob ? '0 : sel_addr;
    assign mem_wdata_o   = sel_wdata;
    assign err_o         = err_q;

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter with a behavioural 1-cycle-read memory behind it.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_arr_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        err;
    logic [63:0] mem [0:1023];

    int vectors;
    int miscompares;

    arr_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(64)) bus ();

    arr_port_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (10),
        .DATA_W  (64),
        .DEPTH   (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_if      (bus),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        bus.req   = r;
        bus.lock  = l;
        bus.we    = w;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 10'd10, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 10'd0) begin miscompares++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", bus.rvalid); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL reset_release_gnt: got %b want 01", bus.gnt); end
        vectors++; if (mem_addr !== 10'd10) begin miscompares++; $display("FAIL reset_release_addr: got %0d want 10", mem_addr); end
        bus.req = 2'b00;
    endtask

    task automatic test_fairness;
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        logic [9:0] exp_a;
        prev_g = 2'b00;
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 10'd10, 10'd20, 64'd0, 64'd0);
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 10'd10 : 10'd20;
            #1;
            vectors++; if (bus.gnt !== exp_g) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); end
            vectors++; if (mem_addr !== exp_a) begin miscompares++; $display("FAIL rr_addr[%0d]: got %0d want %0d", i, mem_addr, exp_a); end
            if (i > 0) begin
                vectors++; if (bus.rvalid !== prev_g) begin miscompares++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, bus.rvalid, prev_g); end
            end
            prev_g = exp_g;
            @(negedge clk);
        end
        #1;
        vectors++; if (bus.rvalid !== 2'b10) begin miscompares++; $display("FAIL rr_rvalid_last: got %b want 10", bus.rvalid); end
        bus.req = 2'b00;
    endtask

    task automatic test_read_latency;
        logic [9:0]  addrs [3];
        logic [63:0] datas [3];
        addrs = '{10'd5, 10'd6, 10'd7};
        datas = '{64'd42, 64'd66, 64'd77};
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rd_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        bus.req = 2'b00;
        #1;
        vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL rd_rvalid_t1: got %b want 01", bus.rvalid); end
        vectors++; if (bus.rdata !== 64'd42) begin miscompares++; $display("FAIL rd_rdata_t1: got %0d want 42", bus.rdata); end
        @(negedge clk);
        #1;
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL rd_rvalid_t2: got %b want 00", bus.rvalid); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(2'b01, 2'b00, 2'b00, addrs[i], 10'd0, 64'd0, 64'd0);
            else       bus.req = 2'b00;
            #1;
            if (i > 0) begin
                vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL b2b_rvalid[%0d]: got %b want 01", i, bus.rvalid); end
                vectors++; if (bus.rdata !== datas[i-1]) begin miscompares++; $display("FAIL b2b_rdata[%0d]: got %0d want %0d", i, bus.rdata, datas[i-1]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock_rmw;
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL rmw_pre_gnt: got %b want 10", bus.gnt); end
        @(negedge clk);
        drive(2'b11, 2'b01, 2'b00, 10'd3, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rmw_read_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        #1;
        vectors++; if (bus.rdata !== 64'd100) begin miscompares++; $display("FAIL rmw_old: got %0d want 100", bus.rdata); end
        drive(2'b11, 2'b00, 2'b01, 10'd3, 10'd20, 64'd107, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rmw_write_gnt: got %b want 01", bus.gnt); end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rmw_mem_we: got %b want 1", mem_we); end
        vectors++; if (mem_wdata !== 64'd107) begin miscompares++; $display("FAIL rmw_wdata: got %0d want 107", mem_wdata); end
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 10'd3, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL rmw_req1_gnt: got %b want 10", bus.gnt); end
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL rmw_write_rvalid: got %b want 00", bus.rvalid); end
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 10'd3, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL rmw_rb_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        bus.req = 2'b00;
        #1;
        vectors++; if (bus.rdata !== 64'd107) begin miscompares++; $display("FAIL rmw_readback: got %0d want 107", bus.rdata); end
    endtask

    task automatic test_lock_drop;
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b00, 10'd5, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL drop_take_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        drive(2'b11, 2'b01, 2'b00, 10'd5, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL drop_hold_gnt: got %b want 01", bus.gnt); end
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b00, 10'd5, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL drop_release_gnt: got %b want 10", bus.gnt); end
        @(negedge clk);
        bus.req = 2'b00;
    endtask

    task automatic test_reset_midlock;
        @(negedge clk);
        drive(2'b10, 2'b10, 2'b00, 10'd5, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL midrst_take_gnt: got %b want 10", bus.gnt); end
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd20, 64'd0, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL midrst_gnt: got %b want 00", bus.gnt); end
        @(negedge clk);
        #1;
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL midrst_rvalid: got %b want 00", bus.rvalid); end
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_unlock_gnt: got %b want 01", bus.gnt); end
        bus.req = 2'b00;
    endtask

    task automatic test_bounds;
        logic        exp_err;
        logic        exp_we;
        logic [9:0]  exp_addr;
        logic [63:0] exp_rd;
`ifdef ARR_ARB_BOUNDS_EN
        exp_err = 1'b1; exp_we = 1'b0; exp_addr = 10'd0;    exp_rd = 64'd0;
`else
        exp_err = 1'b0; exp_we = 1'b1; exp_addr = 10'd1000; exp_rd = 64'd99;
`endif
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b01, 10'd1000, 10'd0, 64'd99, 64'd0);
        #1;
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL oob_wr_gnt: got %b want 01", bus.gnt); end
        vectors++; if (mem_we !== exp_we) begin miscompares++; $display("FAIL oob_wr_we: got %b want %b", mem_we, exp_we); end
        vectors++; if (mem_addr !== exp_addr) begin miscompares++; $display("FAIL oob_wr_addr: got %0d want %0d", mem_addr, exp_addr); end
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 10'd1000, 10'd0, 64'd0, 64'd0);
        #1;
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL oob_wr_err: got %b want %b", err, exp_err); end
        @(negedge clk);
        bus.req = 2'b00;
        #1;
        vectors++; if (bus.rvalid !== 2'b01) begin miscompares++; $display("FAIL oob_rd_rvalid: got %b want 01", bus.rvalid); end
        vectors++; if (bus.rdata !== exp_rd) begin miscompares++; $display("FAIL oob_rd_rdata: got %0d want %0d", bus.rdata, exp_rd); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL oob_rd_err: got %b want %b", err, exp_err); end
        @(negedge clk);
        #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL oob_err_clear: got %b want 0", err); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 64'(i) + 64'd1000;
        mem[3] = 64'd100;
        mem[5] = 64'd42;
        mem[6] = 64'd66;
        mem[7] = 64'd77;
        mem[1000] = 64'd55;
        test_reset;
        test_fairness;
        test_read_latency;
        test_lock_rmw;
        test_lock_drop;
        test_reset_midlock;
        test_bounds;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
